sha256_compress_ctrl: RTL and testbench
=======================================

Name: sha256_compress_ctrl

Overview:
- Sequences the combinational sha256_round datapath through the 64 rounds of one SHA-256 compression for a single 512-bit block.
- Owns the round counter, K-constant selection, the 16-word sliding message-schedule window and the working-variable registers.
- Performs the final chaining-value addition and presents the 256-bit result on a valid/ready handshake.
- Sits between the mining/hash front end (block and midstate supplier) and the digest consumer (second hash pass or target compare).

Parameters:
- UNROLL, 1: sha256_round instances chained per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  block and chaining value are presented
- in_ready  output  1  controller can accept a block
- block_in  input  512  message block; word W0 = bits [511:480], big-endian words
- hash_in  input  256  chaining value H0..H7; H0 = bits [255:224]
- out_valid  output  1  digest is valid
- out_ready  input  1  consumer accepts the digest
- digest_out  output  256  hash_in + final working variables; same word order as hash_in
- busy  output  1  high in ROUND or FINAL

Behaviour:
- Reset is synchronous. While rst is high:
  - state = IDLE, round counter = 0.
  - in_ready = 0, out_valid = 0, busy = 0.
  - digest_out = 0; working, window and hash registers = 0.
- The first cycle after rst deasserts has in_ready = 1.
- rst asserted in any state, including mid-round, discards the job with no output. Takes effect at the next edge.

State machine:
- IDLE (in_ready = 1): on in_valid & in_ready at edge E0:
  - Register hash_in into the hash register and into a..h.
  - Load window[0..15] = block_in words.
  - t = 0; go to ROUND.
- ROUND: at each edge apply UNROLL consecutive rounds t .. t+UNROLL-1 through chained sha256_round instances, using W[t+i] and K[t+i]. Then t += UNROLL.
  - When the rounds applied at this edge include round 63, go to FINAL.
- FINAL: at one edge, digest_out[j] = hash register word j + working variable j, each mod 2^32. Set out_valid = 1 and go to DONE.
- DONE: hold out_valid and digest_out stable until out_valid & out_ready.
  - At that edge clear out_valid and go to IDLE.
  - in_ready stays 0 in DONE; no overlap with the next accept.

Latency and throughput:
- out_valid rises at edge E0 + 64/UNROLL + 1. That is E65 for UNROLL = 1, E33 for 2, E17 for 4.
- Initiation interval is at least 64/UNROLL + 2 cycles.

Message schedule:
- For t >= 16: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
- The window shifts by UNROLL words per ROUND edge. Each chained round consumes the window head in order.

Other rules:
- All additions are 32-bit wrap-around; carries are discarded.
- block_in and hash_in are sampled only at the accept edge. Changes at any other time are ignored.
- in_valid asserted while not IDLE is not accepted; the upstream must hold it.
- out_ready asserted while out_valid = 0 has no effect.

Decomposition:
- Shared header sha256_consts.vh holds:
  - K[0..63] as a 64-entry constant function, indexed 6-bit.
  - The standard IV H0..H7.
  - State encodings IDLE = 0, ROUND = 1, FINAL = 2, DONE = 3.
- sigma0/sigma1/Sigma0/Sigma1/Ch/Maj come from the existing sha256_functions.vh.
- Natural sub-module: sha256_msg_schedule, holding the 16-word window and generating UNROLL words per step, with ports load, step, block_in and w_out[UNROLL*32].
- The round datapath reuses sha256_round, instantiated UNROLL times.

Test Plan:
- "abc" (UNROLL=1):
  - Stimulus: block = 61626380, then 14 words of 00000000, then 00000018; hash_in = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - Required: digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid first high exactly 65 cycles after the accept edge.
- Empty message (UNROLL=1 and UNROLL=4):
  - Stimulus: block = 80000000 followed by 15 zero words; hash_in = IV.
  - Required: digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; latency 65 and 17 respectively.
- Output backpressure:
  - Stimulus: "abc" job with out_ready held low for 10 cycles after out_valid rises.
  - Required: digest_out stable and in_ready = 0 throughout; IDLE and in_ready = 1 the cycle after the out_ready handshake.
- Busy-time input:
  - Stimulus: in_valid held high with a different block during ROUND.
  - Required: not accepted; the first digest is the original job's; the held block is accepted in the cycle after the DONE handshake.
- Reset mid-operation:
  - Stimulus: rst pulsed for 1 cycle at round 30.
  - Required: out_valid never asserts for that job; in_ready = 1 the cycle after reset; a subsequent "abc" job still produces the correct digest.
- Back-to-back:
  - Stimulus: two blocks, with out_ready tied high.
  - Required: two correct digests, with out_valid pulses 66 cycles apart for UNROLL=1.

Source files
------------

// File: rtl/sha256_compress_ctrl_pkg.sv
// rtl/sha256_compress_ctrl_pkg.sv - shared state encoding, round constants and SHA-256 bit functions
package sha256_compress_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [0:63][31:0] K_TABLE = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] k_const(input logic [5:0] idx);
      return K_TABLE[idx];
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - 16-word sliding message window, advances UNROLL words per step
module sha256_msg_schedule
   import sha256_compress_ctrl_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic [511:0]         block_in,
   output logic [UNROLL*32-1:0] w_out
);

   logic [31:0] win [16];
   logic [31:0] ext [16+UNROLL];

   // Words generated later in the same step feed the ones after them.
   always_comb begin : extend
      logic [31:0] e [16+UNROLL];
      for (int i = 0; i < 16; i++) e[i] = win[i];
      for (int j = 0; j < UNROLL; j++)
         e[16+j] = small_sigma1(e[14+j]) + e[9+j] + small_sigma0(e[1+j]) + e[j];
      ext = e;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
      end else if (step) begin
         for (int i = 0; i < 16; i++) win[i] <= ext[i+UNROLL];
      end
   end

   for (genvar g = 0; g < UNROLL; g++) begin : g_wout
      assign w_out[32*g +: 32] = win[g];
   end

endmodule

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round; state word a in bits [255:224], h in [31:0]
module sha256_round
   import sha256_compress_ctrl_pkg::*;
(
   input  logic [255:0] state_in,
   input  logic [31:0]  k,
   input  logic [31:0]  w,
   output logic [255:0] state_out
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] t1, t2;

   assign {a, b, c, d, e, f, g, h} = state_in;
   assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
   assign t2 = big_sigma0(a) + maj(a, b, c);
   assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress_ctrl.sv
// rtl/sha256_compress_ctrl.sv - sequences 64 SHA-256 rounds over one block and adds the chaining value
module sha256_compress_ctrl
   import sha256_compress_ctrl_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] block_in,
   input  logic [255:0] hash_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] digest_out,
   output logic         busy
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("sha256_compress_ctrl: UNROLL must be 1, 2 or 4");
   end

   state_t                state;
   logic [5:0]            rnd;
   logic [255:0]          work;
   logic [255:0]          hash_r;
   logic [255:0]          round_out;
   logic [UNROLL*32-1:0]  w_win;
   logic                  accept;

   assign accept = (state == ST_IDLE) && in_valid && in_ready;

   sha256_msg_schedule #(.UNROLL(UNROLL)) u_sched (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step     (state == ST_ROUND),
      .block_in (block_in),
      .w_out    (w_win)
   );

   for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
      logic [255:0] st_in;
      logic [255:0] st_out;
      if (g == 0) begin : g_first
         assign st_in = work;
      end else begin : g_next
         assign st_in = g_rnd[g-1].st_out;
      end
      sha256_round u_round (
         .state_in  (st_in),
         .k         (k_const(rnd + 6'(g))),
         .w         (w_win[32*g +: 32]),
         .state_out (st_out)
      );
   end

   assign round_out = g_rnd[UNROLL-1].st_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rnd        <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         digest_out <= '0;
         work       <= '0;
         hash_r     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  hash_r   <= hash_in;
                  work     <= hash_in;
                  rnd      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_ROUND;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ST_ROUND: begin
               work <= round_out;
               rnd  <= rnd + 6'(UNROLL);
               // the last group of rounds is the one that contains round 63
               if (rnd == 6'(64 - UNROLL)) state <= ST_FINAL;
            end
            ST_FINAL: begin
               for (int j = 0; j < 8; j++)
                  digest_out[32*j +: 32] <= hash_r[32*j +: 32] + work[32*j +: 32];
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// tb/tb_sha256_compress_ctrl.sv - directed checks of sha256_compress_ctrl with UNROLL 1 and 4
module tb_sha256_compress_ctrl;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_D     = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_D   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [1:0]        in_valid, out_ready;
   logic [511:0]      blk [2];
   logic [255:0]      hin [2];
   logic              ir_a, ir_b, ov_a, ov_b, bz_a, bz_b;
   logic [255:0]      dg_a, dg_b;
   logic [1:0]        in_ready, out_valid, busy;
   logic [1:0][255:0] dig;

   assign in_ready  = {ir_b, ir_a};
   assign out_valid = {ov_b, ov_a};
   assign busy      = {bz_b, bz_a};
   assign dig       = {dg_b, dg_a};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   sha256_compress_ctrl #(.UNROLL(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir_a),
      .block_in(blk[0]), .hash_in(hin[0]), .out_valid(ov_a), .out_ready(out_ready[0]),
      .digest_out(dg_a), .busy(bz_a)
   );

   sha256_compress_ctrl #(.UNROLL(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir_b),
      .block_in(blk[1]), .hash_in(hin[1]), .out_valid(ov_b), .out_ready(out_ready[1]),
      .digest_out(dg_b), .busy(bz_b)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int u, input logic [511:0] b, input logic [255:0] h, input int stall,
                          input logic [255:0] exp_d, input int exp_lat, input string tag);
      int n;
      int t0;
      in_valid[u] = 1'b1;
      blk[u] = b;
      hin[u] = h;
      n = 0;
      while (!in_ready[u] && n < 100) begin tick(); n++; end
      chk({tag, "_ready"}, 256'(in_ready[u]), 256'(1));
      tick();
      t0 = cyc;
      in_valid[u] = 1'b0;
      blk[u] = {16{32'hdeadbeef}};
      hin[u] = '1;
      chk({tag, "_busy"}, 256'(busy[u]), 256'(1));
      n = 0;
      while (!out_valid[u] && n < 200) begin tick(); n++; end
      chk({tag, "_latency"}, 256'(cyc - t0), 256'(exp_lat));
      chk({tag, "_digest"}, dig[u], exp_d);
      for (int i = 0; i < stall; i++) begin
         out_ready[u] = 1'b0;
         tick();
         chk({tag, "_hold_digest"}, dig[u], exp_d);
         chk({tag, "_hold_inready"}, 256'({in_ready[u], out_valid[u], busy[u]}), 256'(3'b010));
      end
      out_ready[u] = 1'b1;
      tick();
      out_ready[u] = 1'b0;
      chk({tag, "_post_hs"}, 256'({in_ready[u], out_valid[u]}), 256'(2'b10));
   endtask

   initial begin
      int n;
      int seen;
      int nacc, nrise, nfall, r1, f1, r2;
      logic prev_ov, acc;
      logic [255:0] d1, d2;

      rst = 1'b1;
      in_valid = '0;
      out_ready = '0;
      for (int i = 0; i < 2; i++) begin blk[i] = '0; hin[i] = '0; end
      repeat (3) tick();
      chk("reset_flags", 256'({in_ready, out_valid, busy}), 256'(0));
      chk("reset_digest_u1", dig[0], 256'(0));
      chk("reset_digest_u4", dig[1], 256'(0));
      rst = 1'b0;
      tick();
      chk("ready_after_reset", 256'(in_ready), 256'(2'b11));

      run_job(0, ABC_BLK, IV, 0, ABC_D, 65, "abc_u1");
      run_job(0, EMPTY_BLK, IV, 0, EMPTY_D, 65, "empty_u1");
      run_job(1, EMPTY_BLK, IV, 0, EMPTY_D, 17, "empty_u4");
      run_job(1, ABC_BLK, IV, 0, ABC_D, 17, "abc_u4");
      run_job(0, ABC_BLK, IV, 10, ABC_D, 65, "backpressure");

      // busy-time input: a second block is held on in_valid while the first is running
      in_valid[0] = 1'b1;
      blk[0] = ABC_BLK;
      hin[0] = IV;
      chk("busyin_ready", 256'(in_ready[0]), 256'(1));
      tick();
      blk[0] = EMPTY_BLK;
      repeat (5) tick();
      chk("busyin_not_accepted", 256'({in_ready[0], busy[0]}), 256'(2'b01));
      n = 0;
      while (!out_valid[0] && n < 200) begin tick(); n++; end
      chk("busyin_first_digest", dig[0], ABC_D);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      chk("busyin_idle_after_hs", 256'(in_ready[0]), 256'(1));
      tick();
      in_valid[0] = 1'b0;
      chk("busyin_held_accepted", 256'({in_ready[0], busy[0]}), 256'(2'b01));
      n = 0;
      while (!out_valid[0] && n < 200) begin tick(); n++; end
      chk("busyin_second_digest", dig[0], EMPTY_D);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;

      // reset in the middle of round 30
      in_valid[0] = 1'b1;
      blk[0] = ABC_BLK;
      n = 0;
      while (!in_ready[0] && n < 100) begin tick(); n++; end
      tick();
      in_valid[0] = 1'b0;
      repeat (30) tick();
      rst = 1'b1;
      tick();
      chk("midrst_flags", 256'({in_ready[0], out_valid[0], busy[0]}), 256'(0));
      chk("midrst_digest", dig[0], 256'(0));
      rst = 1'b0;
      tick();
      chk("midrst_ready", 256'(in_ready[0]), 256'(1));
      seen = 0;
      repeat (80) begin tick(); if (out_valid[0]) seen++; end
      chk("midrst_no_output", 256'(seen), 256'(0));
      run_job(0, ABC_BLK, IV, 0, ABC_D, 65, "after_rst");

      // back-to-back with out_ready tied high
      out_ready[0] = 1'b1;
      in_valid[0] = 1'b1;
      blk[0] = ABC_BLK;
      hin[0] = IV;
      nacc = 0; nrise = 0; nfall = 0; r1 = 0; f1 = 0; r2 = 0;
      prev_ov = 1'b0;
      d1 = '0; d2 = '0;
      for (int k = 0; k < 400 && nfall < 2; k++) begin
         acc = in_ready[0] & in_valid[0];
         tick();
         if (acc) begin
            nacc++;
            if (nacc == 1) blk[0] = EMPTY_BLK;
            else in_valid[0] = 1'b0;
         end
         if (out_valid[0] && !prev_ov) begin
            nrise++;
            if (nrise == 1) begin r1 = cyc; d1 = dig[0]; end
            else begin r2 = cyc; d2 = dig[0]; end
         end
         if (!out_valid[0] && prev_ov) begin
            nfall++;
            if (nfall == 1) f1 = cyc;
         end
         prev_ov = out_valid[0];
      end
      out_ready[0] = 1'b0;
      chk("b2b_pulses", 256'(nrise), 256'(2));
      chk("b2b_digest1", d1, ABC_D);
      chk("b2b_digest2", d2, EMPTY_D);
      chk("b2b_pulse_width", 256'(f1 - r1), 256'(1));
      chk("b2b_gap", 256'(r2 - f1), 256'(66));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
